if_queue: RTL



---
 rtl/ifq_pkg.sv | 14 +
 rtl/ifq_ram.sv | 35 +++
 rtl/if_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and defaults for the fetch-to-decode instruction queue.
//   ifq_entry_t        : one queued fetch result {pc, inst, jump}
//   IFQ_DEPTH_DEFAULT  : default number of queue entries
package ifq_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jump;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// ifq_ram: DEPTH x ifq_entry_t register file, one synchronous write port and
// one asynchronous read port. The data array has no reset; validity is tracked
// by the queue pointers in if_queue.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module ifq_ram
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ifq_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output ifq_entry_t       rdata
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_queue.sv
// if_queue: in-order queue between the IM response path and the decode stage.
// Holds fetched {pc, inst, jump} entries, presents the head to decode with an
// IF_valid/DC_ready handshake, hands out request credits to fetch and, on
// mispredict, flushes all entries and drops every IM response still in flight.
//
// Optional feature macro: IFQ_BYPASS_EN -- when defined, an accepted response
// arriving at an empty queue is presented to decode in the same cycle.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   fetch_req_fire     : fetch issued an IM request this cycle
//   ifq_req_ready      : fetch may issue a request (count + outstanding < DEPTH)
//   im_resp_valid/pc/inst/jump : IM response
//   IF_valid, DC_in_pc/inst/jump : head entry to decode (zeros when empty)
//   DC_ready           : decode accepts the head this cycle
//   mispredict         : flush request
//   ifq_count          : current occupancy
module if_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req_fire,
    output logic             ifq_req_ready,
    input  logic             im_resp_valid,
    input  logic [31:0]      im_resp_pc,
    input  logic [31:0]      im_resp_inst,
    input  logic             im_resp_jump,
    output logic             IF_valid,
    output logic [31:0]      DC_in_pc,
    output logic [31:0]      DC_in_inst,
    output logic             DC_in_jump,
    input  logic             DC_ready,
    input  logic             mispredict,
    output logic [CNT_W-1:0] ifq_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head, head_next;
    logic [PTR_W-1:0] tail, tail_next;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic [CNT_W-1:0] drop_cnt, drop_next;

    logic       empty;
    logic       acc;
    logic       byp;
    logic       deq;
    logic       pop;
    logic       wr_en;
    logic [CNT_W:0] credit_used;

    ifq_entry_t wr_entry;
    ifq_entry_t rd_entry;
    ifq_entry_t head_entry;

    assign empty = (count == '0);

    // Responses are only stored once every stale in-flight response is drained,
    // and never in the flush cycle itself.
    assign acc = im_resp_valid && (drop_cnt == '0) && !mispredict;

`ifdef IFQ_BYPASS_EN
    assign byp = empty && acc;
`else
    assign byp = 1'b0;
`endif

    assign IF_valid = !empty || byp;
    assign deq      = IF_valid && DC_ready;
    // A bypassed response consumed by decode never touches the storage.
    assign pop      = deq && !empty;
    assign wr_en    = acc && !(byp && DC_ready);

    assign wr_entry.pc   = im_resp_pc;
    assign wr_entry.inst = im_resp_inst;
    assign wr_entry.jump = im_resp_jump;

    ifq_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_entry)
    );

    always_comb begin
        head_entry = '0;
        if (!empty) begin
            head_entry = rd_entry;
        end else if (byp) begin
            head_entry = wr_entry;
        end
    end

    assign DC_in_pc   = head_entry.pc;
    assign DC_in_inst = head_entry.inst;
    assign DC_in_jump = head_entry.jump;

    // Credits depend on registered state only; the extra bit keeps the sum exact.
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign ifq_req_ready = credit_used < (CNT_W + 1)'(DEPTH);
    assign ifq_count     = count;

    always_comb begin
        outstanding_next = outstanding + CNT_W'(fetch_req_fire) - CNT_W'(im_resp_valid);
        head_next        = head;
        tail_next        = tail;
        count_next       = count;
        drop_next        = drop_cnt;
        if (mispredict) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            // Everything still in flight after this edge belongs to the wrong path.
            drop_next  = outstanding_next;
        end else begin
            if (pop) begin
                head_next = head + PTR_W'(1);
            end
            if (wr_en) begin
                tail_next = tail + PTR_W'(1);
            end
            count_next = count + CNT_W'(wr_en) - CNT_W'(pop);
            if (im_resp_valid && (drop_cnt != '0)) begin
                drop_next = drop_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            head        <= head_next;
            tail        <= tail_next;
            count       <= count_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
        end
    end

endmodule
